mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the data RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the data RAM word width.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port i_req_valid  in  1  CPU access request present.
REQ-006 SHALL have port i_req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port i_req_addr  in  ADDR_W  access address.
REQ-008 SHALL have port i_req_wdata  in  DATA_W  store data.
REQ-009 SHALL have port o_req_ready  out  1  controller accepts request this cycle.
REQ-010 SHALL have port o_rsp_valid  out  1  load data available.
REQ-011 SHALL have port o_rsp_data  out  DATA_W  load data (MBR).
REQ-012 SHALL have port i_rsp_ready  in  1  CPU consumes response.
REQ-013 SHALL have port o_ram_we  out  1  RAM write strobe.
REQ-014 SHALL have port o_ram_waddr  out  ADDR_W  RAM write address.
REQ-015 SHALL have port o_ram_wdata  out  DATA_W  RAM write data.
REQ-016 SHALL have port o_ram_re  out  1  RAM read enable.
REQ-017 SHALL have port o_ram_raddr  out  ADDR_W  RAM read address.
REQ-018 SHALL have port i_ram_rdata  in  DATA_W  combinational RAM read data; 0 when o_ram_re low.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-020 SHALL drive o_req_ready = 1 only in IDLE.
REQ-021 SHALL, on accept (i_req_valid && o_req_ready), capture address into MAR, i_req_wdata into MBR, and go to WRITE if i_req_we else READ.
REQ-022 SHALL, in WRITE, assert o_ram_we for exactly one cycle with MAR/MBR on o_ram_waddr/o_ram_wdata, then return to IDLE; stores produce no response.
REQ-023 SHALL, in READ, assert o_ram_re for exactly one cycle with MAR on o_ram_raddr, load i_ram_rdata into MBR at that cycle's edge, then go to RESP.
REQ-024 SHALL, in RESP, hold o_rsp_valid = 1 and o_rsp_data = MBR stable until i_rsp_ready = 1, then return to IDLE.
REQ-025 SHALL have latency: accept at cycle T -> RAM strobe at T+1 -> o_rsp_valid at T+2 (loads); store visible to RAM reads from T+2.
REQ-026 SHALL ignore request inputs outside IDLE; the requester holds them until accepted.
REQ-027 SHALL keep o_ram_we and o_ram_re mutually exclusive and never asserted in IDLE or RESP.
REQ-028 SHALL drive o_ram_waddr/o_ram_raddr from MAR and o_ram_wdata from MBR at all times.
REQ-029 SHALL treat address 0xFF like any other address (no wrap logic, no range check).

Reset
REQ-030 SHALL, while i_rst_n = 0 at a clock edge, force IDLE, MAR = 0, MBR = 0, o_rsp_valid = 0, o_ram_we = 0, o_ram_re = 0 (o_req_ready = 1 after release).
REQ-031 SHALL, on reset in WRITE/READ/RESP, abort the access with no strobe after the reset edge; the pending response is discarded.

Configuration
REQ-032 SHALL compile, under macro MEM_ACCESS_CTRL_STATS_EN, outputs o_rd_cnt and o_wr_cnt (16 bit each) counting o_ram_re and o_ram_we cycles, saturating at 0xFFFF and reset to 0.
REQ-033 SHALL, without MEM_ACCESS_CTRL_STATS_EN, omit those ports and counters entirely; other behaviour identical.

Structure
REQ-034 SHALL take ADDR_W/DATA_W defaults and the FSM state encoding from a shared package mem_pkg.
REQ-035 SHALL implement each stats counter as an instance of sub-module sat_counter (width parameter, inc, sync active-low clear).

Verification
REQ-036 SHALL pass: store addr 0x10 data 0xBEEF, then load 0x10 -> o_ram_we one cycle at T+1, o_rsp_data = 0xBEEF with o_rsp_valid at load-accept+2.
REQ-037 SHALL pass: load with i_rsp_ready held 0 for 5 cycles -> o_rsp_valid and data stable 5 cycles, o_req_ready = 0 throughout, IDLE one cycle after handshake.
REQ-038 SHALL pass: back-to-back stores to 0x00 and 0xFF with i_req_valid held high -> accepts every 2 cycles, both addresses written once.
REQ-039 SHALL pass: reset asserted in RESP -> o_rsp_valid = 0 the next cycle, no RAM strobe, o_req_ready = 1 after release.
REQ-040 SHALL pass, with MEM_ACCESS_CTRL_STATS_EN: 3 stores, 2 loads -> o_wr_cnt = 3, o_rd_cnt = 2; counter preset near 0xFFFF holds at 0xFFFF after further loads.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: default widths and
// the controller FSM state encoding.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear. Holds at all-ones
// instead of wrapping; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  // Count up on each inc cycle until every bit is set, then stick there.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side data RAM access controller. A request is latched into MAR/MBR in
// IDLE, then a single write or read strobe is issued; loads are returned via
// a valid/ready response held until consumed.
// Optional feature: define MEM_ACCESS_CTRL_STATS_EN to add saturating 16-bit
// read/write strobe counters on o_rd_cnt / o_wr_cnt.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  input  logic              i_rsp_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_re,
  output logic [ADDR_W-1:0] o_ram_raddr,
  input  logic [DATA_W-1:0] i_ram_rdata
`ifdef MEM_ACCESS_CTRL_STATS_EN
  ,
  output logic [15:0]       o_rd_cnt,
  output logic [15:0]       o_wr_cnt
`endif
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic              accept;

  assign accept      = i_req_valid && o_req_ready;
  assign o_rsp_data  = mbr;
  assign o_ram_waddr = mar;
  assign o_ram_raddr = mar;
  assign o_ram_wdata = mbr;

  // State register; reset drops any in-flight access back to IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; every strobe is a pure function of state.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_re    = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_d = i_req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        o_ram_we = 1'b1;
        state_d  = IDLE;
      end
      READ: begin
        o_ram_re = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MAR/MBR: capture the request on accept, then the RAM word during READ.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mar <= '0;
      mbr <= '0;
    end else if (accept) begin
      mar <= i_req_addr;
      mbr <= i_req_wdata;
    end else if (state_q == READ) begin
      mbr <= i_ram_rdata;
    end
  end

`ifdef MEM_ACCESS_CTRL_STATS_EN
  sat_counter #(.WIDTH(16)) u_rd_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .i_inc   (o_ram_re),
    .o_count (o_rd_cnt)
  );

  sat_counter #(.WIDTH(16)) u_wr_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .i_inc   (o_ram_we),
    .o_count (o_wr_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 256-word RAM model.
// Stats checks are compiled in only when MEM_ACCESS_CTRL_STATS_EN is defined.
module tb_mem_access_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        i_req_we;
  logic [7:0]  i_req_addr;
  logic [15:0] i_req_wdata;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [15:0] o_rsp_data;
  logic        i_rsp_ready;
  logic        o_ram_we;
  logic [7:0]  o_ram_waddr;
  logic [15:0] o_ram_wdata;
  logic        o_ram_re;
  logic [7:0]  o_ram_raddr;
  logic [15:0] i_ram_rdata;
`ifdef MEM_ACCESS_CTRL_STATS_EN
  logic [15:0] o_rd_cnt;
  logic [15:0] o_wr_cnt;
`endif

  logic        sc_clr_n;
  logic        sc_inc;
  logic [1:0]  sc_count;

  logic [15:0] ram [0:255];
  int          wr_hits [0:255];
  int          we_total;
  int          re_total;
  int          checks;
  int          errors;

  always #5 i_clk = ~i_clk;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .i_rsp_ready (i_rsp_ready),
    .o_ram_we    (o_ram_we),
    .o_ram_waddr (o_ram_waddr),
    .o_ram_wdata (o_ram_wdata),
    .o_ram_re    (o_ram_re),
    .o_ram_raddr (o_ram_raddr),
    .i_ram_rdata (i_ram_rdata)
`ifdef MEM_ACCESS_CTRL_STATS_EN
    ,
    .o_rd_cnt    (o_rd_cnt),
    .o_wr_cnt    (o_wr_cnt)
`endif
  );

  sat_counter #(.WIDTH(2)) u_sc (
    .i_clk   (i_clk),
    .i_clr_n (sc_clr_n),
    .i_inc   (sc_inc),
    .o_count (sc_count)
  );

  // Combinational RAM read port: zero whenever the read enable is low.
  assign i_ram_rdata = o_ram_re ? ram[o_ram_raddr] : 16'h0000;

  // RAM write port plus strobe bookkeeping.
  always @(posedge i_clk) begin
    if (o_ram_we) begin
      ram[o_ram_waddr]     <= o_ram_wdata;
      wr_hits[o_ram_waddr] <= wr_hits[o_ram_waddr] + 1;
      we_total             <= we_total + 1;
    end
    if (o_ram_re) begin
      re_total <= re_total + 1;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic valid, input logic we,
                           input logic [7:0] addr, input logic [15:0] wdata);
    i_req_valid = valid;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wdata;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    i_rsp_ready = 1'b0;
    tick();
    tick();
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid got %b exp 0", o_rsp_valid); end
    checks++; if (o_ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_we got %b exp 0", o_ram_we); end
    checks++; if (o_ram_re !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_re got %b exp 0", o_ram_re); end
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_ready got %b exp 1", o_req_ready); end
    checks++; if (o_rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mbr got %h exp 0000", o_rsp_data); end
    checks++; if (o_ram_waddr !== 8'h00) begin errors++; $display("[TB] FAIL rst_mar got %h exp 00", o_ram_waddr); end
  endtask

  task automatic test_store_load();
    drive_req(1'b1, 1'b1, 8'h10, 16'hBEEF);
    tick();
    checks++; if (o_ram_we !== 1'b1) begin errors++; $display("[TB] FAIL st_we got %b exp 1", o_ram_we); end
    checks++; if (o_ram_waddr !== 8'h10) begin errors++; $display("[TB] FAIL st_waddr got %h exp 10", o_ram_waddr); end
    checks++; if (o_ram_wdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL st_wdata got %h exp beef", o_ram_wdata); end
    checks++; if (o_req_ready !== 1'b0 || o_ram_re !== 1'b0) begin errors++; $display("[TB] FAIL st_ready_re got %b%b exp 00", o_req_ready, o_ram_re); end
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    checks++; if (o_ram_we !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL st_done got we=%b rdy=%b exp we=0 rdy=1", o_ram_we, o_req_ready); end
    checks++; if (ram[8'h10] !== 16'hBEEF) begin errors++; $display("[TB] FAIL st_ram got %h exp beef", ram[8'h10]); end
    drive_req(1'b1, 1'b0, 8'h10, 16'h1234);
    i_rsp_ready = 1'b1;
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    checks++; if (o_ram_re !== 1'b1 || o_ram_we !== 1'b0) begin errors++; $display("[TB] FAIL ld_re got re=%b we=%b exp re=1 we=0", o_ram_re, o_ram_we); end
    checks++; if (o_ram_raddr !== 8'h10) begin errors++; $display("[TB] FAIL ld_raddr got %h exp 10", o_ram_raddr); end
    checks++; if (o_ram_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL ld_mbr_capture got %h exp 1234", o_ram_wdata); end
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ld_early_valid got %b exp 0", o_rsp_valid); end
    tick();
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ld_valid got %b exp 1", o_rsp_valid); end
    checks++; if (o_rsp_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL ld_data got %h exp beef", o_rsp_data); end
    tick();
    checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL ld_done got v=%b rdy=%b exp v=0 rdy=1", o_rsp_valid, o_req_ready); end
  endtask

  task automatic test_resp_stall();
    ram[8'h33] = 16'hA5A5;
    i_rsp_ready = 1'b0;
    drive_req(1'b1, 1'b0, 8'h33, 16'h0000);
    tick();
    // A store held during the stall must be ignored until IDLE returns.
    drive_req(1'b1, 1'b1, 8'h44, 16'h4444);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'hA5A5) begin errors++; $display("[TB] FAIL stall_rsp[%0d] got v=%b d=%h exp v=1 d=a5a5", i, o_rsp_valid, o_rsp_data); end
      checks++; if (o_req_ready !== 1'b0 || o_ram_we !== 1'b0 || o_ram_re !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle[%0d] got rdy=%b we=%b re=%b exp 000", i, o_req_ready, o_ram_we, o_ram_re); end
      if (i < 4) tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got rdy=%b v=%b exp rdy=1 v=0", o_req_ready, o_rsp_valid); end
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    i_rsp_ready = 1'b0;
    checks++; if (o_ram_we !== 1'b1 || o_ram_waddr !== 8'h44 || o_ram_wdata !== 16'h4444) begin errors++; $display("[TB] FAIL held_store got we=%b a=%h d=%h exp we=1 a=44 d=4444", o_ram_we, o_ram_waddr, o_ram_wdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int we_base;
    we_base = we_total;
    wr_hits[8'h00] = 0;
    wr_hits[8'hFF] = 0;
    drive_req(1'b1, 1'b1, 8'h00, 16'h1111);
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rdy0 got %b exp 1", o_req_ready); end
    tick();
    checks++; if (o_ram_we !== 1'b1 || o_ram_waddr !== 8'h00 || o_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_w0 got we=%b a=%h rdy=%b exp we=1 a=00 rdy=0", o_ram_we, o_ram_waddr, o_req_ready); end
    drive_req(1'b1, 1'b1, 8'hFF, 16'h2222);
    tick();
    checks++; if (o_req_ready !== 1'b1 || o_ram_we !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rdy1 got rdy=%b we=%b exp rdy=1 we=0", o_req_ready, o_ram_we); end
    tick();
    checks++; if (o_ram_we !== 1'b1 || o_ram_waddr !== 8'hFF || o_ram_wdata !== 16'h2222) begin errors++; $display("[TB] FAIL b2b_wff got we=%b a=%h d=%h exp we=1 a=ff d=2222", o_ram_we, o_ram_waddr, o_ram_wdata); end
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    checks++; if (wr_hits[8'h00] !== 1 || wr_hits[8'hFF] !== 1) begin errors++; $display("[TB] FAIL b2b_hits got %0d/%0d exp 1/1", wr_hits[8'h00], wr_hits[8'hFF]); end
    checks++; if (ram[8'h00] !== 16'h1111 || ram[8'hFF] !== 16'h2222) begin errors++; $display("[TB] FAIL b2b_data got %h/%h exp 1111/2222", ram[8'h00], ram[8'hFF]); end
    checks++; if (we_total - we_base !== 2) begin errors++; $display("[TB] FAIL b2b_total got %0d exp 2", we_total - we_base); end
  endtask

  task automatic test_reset_in_resp();
    int we_base;
    int re_base;
    ram[8'h55] = 16'h5555;
    i_rsp_ready = 1'b0;
    drive_req(1'b1, 1'b0, 8'h55, 16'h0000);
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h5555) begin errors++; $display("[TB] FAIL rr_pre got v=%b d=%h exp v=1 d=5555", o_rsp_valid, o_rsp_data); end
    we_base = we_total;
    re_base = re_total;
    i_rst_n = 1'b0;
    tick();
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL rr_abort got v=%b d=%h exp v=0 d=0000", o_rsp_valid, o_rsp_data); end
    checks++; if (o_ram_we !== 1'b0 || o_ram_re !== 1'b0) begin errors++; $display("[TB] FAIL rr_strobe got we=%b re=%b exp 00", o_ram_we, o_ram_re); end
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_release got rdy=%b v=%b exp rdy=1 v=0", o_req_ready, o_rsp_valid); end
    checks++; if (we_total !== we_base || re_total !== re_base) begin errors++; $display("[TB] FAIL rr_no_strobe got we+%0d re+%0d exp 0/0", we_total - we_base, re_total - re_base); end
  endtask

  task automatic test_sat_counter();
    sc_clr_n = 1'b0;
    sc_inc   = 1'b1;
    tick();
    checks++; if (sc_count !== 2'd0) begin errors++; $display("[TB] FAIL sat_clear got %0d exp 0", sc_count); end
    sc_clr_n = 1'b1;
    tick();
    tick();
    checks++; if (sc_count !== 2'd2) begin errors++; $display("[TB] FAIL sat_count got %0d exp 2", sc_count); end
    tick();
    tick();
    tick();
    checks++; if (sc_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold got %0d exp 3", sc_count); end
    sc_clr_n = 1'b0;
    tick();
    checks++; if (sc_count !== 2'd0) begin errors++; $display("[TB] FAIL sat_clr_prio got %0d exp 0", sc_count); end
    sc_inc = 1'b0;
  endtask

`ifdef MEM_ACCESS_CTRL_STATS_EN
  task automatic test_stats();
    i_rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    i_rst_n = 1'b1;
    checks++; if (o_rd_cnt !== 16'd0 || o_wr_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stats_rst got rd=%0d wr=%0d exp 0/0", o_rd_cnt, o_wr_cnt); end
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 1'b1, 8'(8'h20 + i), 16'(16'h0100 + i));
      tick();
      drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b1, 1'b0, 8'(8'h20 + i), 16'h0000);
      tick();
      drive_req(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      tick();
    end
    checks++; if (o_wr_cnt !== 16'd3) begin errors++; $display("[TB] FAIL stats_wr got %0d exp 3", o_wr_cnt); end
    checks++; if (o_rd_cnt !== 16'd2) begin errors++; $display("[TB] FAIL stats_rd got %0d exp 2", o_rd_cnt); end
    i_rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    we_total = 0;
    re_total = 0;
    sc_clr_n = 1'b0;
    sc_inc   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'h0000;
      wr_hits[i] = 0;
    end
    $display("[TB] starting mem_access_ctrl bench");
    test_reset();
    test_store_load();
    test_resp_stall();
    test_back_to_back();
    test_reset_in_resp();
    test_sat_counter();
`ifdef MEM_ACCESS_CTRL_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
